// File: rtl/msb_first_serializer_if.sv
// Bundle of the parallel-in / serial-out handshake signals of the MSB-first
// serializer. The master side owns the word source and the bit consumer.
// The slave side is the serializer itself.
interface msb_first_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             data_out;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    // Environment view: supplies words and consumes bits.
    modport master (
        output data_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  out_last
    );

    // Serializer view.
    modport slave (
        input  data_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output data_out,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/msb_first_serializer.sv
// MSB-first serializer: accepts a WIDTH-bit word over a valid/ready handshake
// and emits it one bit per output handshake, MSB first. out_last marks the LSB.
// A new word can be accepted on the last-bit handshake, so streams run with no bubble.
module msb_first_serializer #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    msb_first_serializer_if.slave  bus
);
    localparam int                 CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   shift_left;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;

    logic               in_ready;
    logic               load;
    logic               out_hs;

    // The shift register moves one place toward the MSB. A zero enters at bit 0.
    assign shift_left[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shift_left[gi] = shift_q[gi-1];
        end
    endgenerate

    // Handshakes. in_ready has no path from in_valid, so load cannot form a loop.
    assign load   = bus.in_valid & in_ready;
    assign out_hs = out_valid_q & bus.out_ready;

    // State register. It holds the FSM state, the datapath and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state process. Loads a word, advances one bit per output handshake,
    // and chains or retires on the last bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shift_d = bus.data_in;
                    cnt_d   = CNT_TOP;
                end
            end

            SHIFT: begin
                if (out_hs) begin
                    if (cnt_q != '0) begin
                        shift_d = shift_left;
                        cnt_d   = cnt_q - 1'b1;
                    end else if (load) begin
                        // Last bit leaves and the next word's MSB follows directly.
                        shift_d = bus.data_in;
                        cnt_d   = CNT_TOP;
                    end else begin
                        // Clearing the shifter keeps data_out at 0 while idle.
                        state_d = IDLE;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase

        // The serial outputs are computed from next state, so they leave the block straight from flops.
        data_out_d  = shift_d[WIDTH-1];
        out_valid_d = (state_d == SHIFT);
        out_last_d  = (state_d == SHIFT) && (cnt_d == '0);
    end

    // Output process. in_ready is open in IDLE, or on the last-bit handshake only.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                SHIFT:   in_ready = (cnt_q == '0) && bus.out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_msb_first_serializer.sv
// Directed bench for msb_first_serializer with WIDTH=4.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_msb_first_serializer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    msb_first_serializer_if #(.WIDTH(4)) bus ();

    msb_first_serializer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Move to the falling edge after the next rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expect a valid bit with the given data and last flag.
    task automatic expect_bit(input string tag, input logic d, input logic l);
        check_eq({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_eq({tag, ".data"},  {31'd0, bus.data_out},  {31'd0, d});
        check_eq({tag, ".last"},  {31'd0, bus.out_last},  {31'd0, l});
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
        check_eq({tag, ".last"},  {31'd0, bus.out_last},  32'd0);
    endtask

    logic [7:0] t4_bits;
    logic [7:0] t4_last;

    initial begin
        // 1: reset with in_valid asserted
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 4'hA;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("t1.rst.data",     {31'd0, bus.data_out},  32'd0);
            check_eq("t1.rst.valid",    {31'd0, bus.out_valid}, 32'd0);
            check_eq("t1.rst.last",     {31'd0, bus.out_last},  32'd0);
            check_eq("t1.rst.in_ready", {31'd0, bus.in_ready},  32'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("t1.rel.in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 2: word 1010 with the consumer always ready
        bus.data_in  = 4'b1010;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        expect_bit("t2.b0", 1'b1, 1'b0); tick();
        expect_bit("t2.b1", 1'b0, 1'b0); tick();
        expect_bit("t2.b2", 1'b1, 1'b0); tick();
        expect_bit("t2.b3", 1'b0, 1'b1); tick();
        expect_idle("t2.end");

        // 3: word 0110 with the consumer stalled for 3 clocks on bit index 1
        bus.data_in  = 4'b0110;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        expect_bit("t3.b0", 1'b0, 1'b0); tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_bit("t3.stall", 1'b1, 1'b0);
            check_eq("t3.stall.cnt",      {30'd0, dut.cnt_q},    32'd2);
            check_eq("t3.stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        expect_bit("t3.b1", 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        expect_bit("t3.b2", 1'b1, 1'b0); tick();
        expect_bit("t3.b3", 1'b0, 1'b1); tick();
        expect_idle("t3.end");

        // 4: back-to-back C then 3 with in_valid held
        t4_bits = 8'b1100_0011;
        t4_last = 8'b0001_0001;
        bus.data_in  = 4'hC;
        bus.in_valid = 1'b1;
        tick();
        bus.data_in = 4'h3;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.in_valid = 1'b0;
            #1;
            expect_bit("t4.bit", t4_bits[7-i], t4_last[7-i]);
            check_eq("t4.in_ready", {31'd0, bus.in_ready}, {31'd0, t4_last[7-i]});
            tick();
        end
        expect_idle("t4.end");

        // 5: reset in the middle of word F, then word 8
        bus.data_in  = 4'hF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        expect_bit("t5.b0", 1'b1, 1'b0); tick();
        expect_bit("t5.b1", 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        expect_idle("t5.rst");
        check_eq("t5.rst.data",     {31'd0, bus.data_out}, 32'd0);
        check_eq("t5.rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst          = 1'b0;
        bus.data_in  = 4'h8;
        bus.in_valid = 1'b1;
        #1;
        check_eq("t5.rel.in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        expect_bit("t5.n0", 1'b1, 1'b0); tick();
        expect_bit("t5.n1", 1'b0, 1'b0); tick();
        expect_bit("t5.n2", 1'b0, 1'b0); tick();
        expect_bit("t5.n3", 1'b0, 1'b1); tick();
        expect_idle("t5.end");

        // 6: word 5 offered while word 9 is mid-stream
        bus.data_in  = 4'h9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        expect_bit("t6.a0", 1'b1, 1'b0); tick();
        expect_bit("t6.a1", 1'b0, 1'b0);
        bus.data_in  = 4'h5;
        bus.in_valid = 1'b1;
        #1;
        check_eq("t6.cnt2.in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        expect_bit("t6.a2", 1'b0, 1'b0);
        check_eq("t6.cnt1.in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        expect_bit("t6.a3", 1'b1, 1'b1);
        check_eq("t6.last.in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        expect_bit("t6.n0", 1'b0, 1'b0); tick();
        expect_bit("t6.n1", 1'b1, 1'b0); tick();
        expect_bit("t6.n2", 1'b0, 1'b0); tick();
        expect_bit("t6.n3", 1'b1, 1'b1); tick();
        expect_idle("t6.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
